// File: rtl/bp437_pack8_if.sv
// Handshake bundle between the BP(4,3,7) decoder, the byte packer and the byte-oriented receive path.
// The master drives decoder words and consumer ready; the slave returns the FIFO head.
interface bp437_pack8_if;
  logic       start;
  logic       ce;
  logic [2:0] d;
  logic [7:0] dout;
  logic       dv;
  logic       rdy;
  logic       ovf;

  modport master (output start, ce, d, rdy, input dout, dv, ovf);
  modport slave  (input start, ce, d, rdy, output dout, dv, ovf);
endinterface

// File: rtl/bp437_pack8.sv
// Discards decoder fill words after start, packs 3-bit words LSB-first into bytes, queues them in a show-ahead FIFO.
// Optional descrambler (x^7+x^4+1 LFSR) enabled by defining BP437_DESCRAMBLE_EN.
module bp437_pack8 #(
  parameter int LAT   = 28,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  bp437_pack8_if.slave   bus
);
  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAT_V  = CW'(LAT);
  localparam logic [AW:0]   FULL_V = (AW + 1)'(DEPTH);

  logic [CW-1:0] disc_q;
  logic [9:0]    acc_q;
  logic [2:0]    cnt_q;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   occ_q;
  logic [7:0]    dout_q;
  logic          ovf_q;

  logic          pack, push, pop, full, push_ok;
  logic [2:0]    bits;
  logic [9:0]    acc_app, acc_d;
  logic [3:0]    cnt_sum;
  logic [2:0]    cnt_d;
  logic [AW:0]   occ_pop, occ_d;
  logic [AW-1:0] rd_d;
  logic [7:0]    head_d;

`ifdef BP437_DESCRAMBLE_EN
  logic [7:1] lfsr_q, lfsr_d;
  logic [2:0] key;

  // Three LFSR steps per packed word, one key bit per data bit, d[0] first.
  always_comb begin
    lfsr_d = lfsr_q;
    key    = '0;
    for (int i = 0; i < 3; i++) begin
      key[i] = lfsr_d[7] ^ lfsr_d[4];
      lfsr_d = {lfsr_d[6:1], key[i]};
    end
  end

  assign bits = bus.d ^ key;

  always_ff @(posedge clk) begin
    if (rst || bus.start) lfsr_q <= 7'h7F;
    else if (pack)        lfsr_q <= lfsr_d;
  end
`else
  assign bits = bus.d;
`endif

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pack    = bus.ce && !bus.start && (disc_q == '0);
    acc_app = acc_q | ({7'd0, bits} << cnt_q);
    cnt_sum = {1'b0, cnt_q} + 4'd3;
    push    = pack && cnt_sum[3];
    acc_d   = push ? (acc_app >> 8) : acc_app;
    cnt_d   = cnt_sum[2:0];
    full    = (occ_q == FULL_V);
    pop     = bus.rdy && (occ_q != '0);
    push_ok = push && (!full || pop);
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    occ_pop = occ_q - (AW + 1)'(pop);
    occ_d   = occ_pop + (AW + 1)'(push_ok);
    // With nothing left after the pop, the new head is the byte being pushed now.
    head_d  = (occ_pop == '0) ? acc_app[7:0] : mem[rd_d];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      disc_q <= LAT_V;
      acc_q  <= '0;
      cnt_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      occ_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (bus.start) begin
      disc_q <= LAT_V;
      acc_q  <= '0;
      cnt_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      occ_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (bus.ce && (disc_q != '0)) disc_q <= disc_q - CW'(1);
      if (pack) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
      end
      if (push_ok)         wr_q   <= wr_q + AW'(1);
      if (push && !push_ok) ovf_q <= 1'b1;
      if (occ_d != '0)     dout_q <= head_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= acc_app[7:0];
  end

  assign bus.dout = dout_q;
  assign bus.dv   = (occ_q != '0);
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_bp437_pack8.sv
// Bench for bp437_pack8: directed scenarios plus random traffic, checked by a bit-queue model and a byte scoreboard.
// Define BP437_DESCRAMBLE_EN for both bench and RTL to exercise the descrambler.
module tb_bp437_pack8;
  localparam int LAT   = 28;
  localparam int DEPTH = 4;
`ifdef BP437_DESCRAMBLE_EN
  localparam logic [7:0] ZERO_WORDS_BYTE = 8'h70;
`else
  localparam logic [7:0] ZERO_WORDS_BYTE = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp437_pack8_if bus ();
  bp437_pack8 #(.LAT(LAT), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a discard count, a queue of pending bits and a queue of bytes held by the FIFO.
  logic [7:0] exp_q[$];
  bit         bitq[$];
  bit         hist[$];
  int         disc_left;
  bit         ovf_exp;
  logic [7:0] hold_exp;
  bit         mon_en = 1'b0;
  logic       p_rst, p_start, p_ce;
  logic [2:0] p_d;

  function automatic void model_clear();
    exp_q.delete();
    bitq.delete();
    hist.delete();
    for (int i = 0; i < 7; i++) hist.push_back(1'b1);
    ovf_exp   = 1'b0;
    disc_left = LAT;
  endfunction

  // Whitening key stream: k[n] = k[n-7] ^ k[n-4], history seeded with ones.
  function automatic bit next_key();
    bit k;
`ifdef BP437_DESCRAMBLE_EN
    k = hist[0] ^ hist[3];
    void'(hist.pop_front());
    hist.push_back(k);
`else
    k = 1'b0;
`endif
    return k;
  endfunction

  function automatic void model_word(input logic [2:0] w);
    logic [7:0] b;
    if (disc_left > 0) begin
      disc_left--;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      bitq.push_back(w[i] ^ next_key());
      if (bitq.size() == 8) begin
        for (int j = 0; j < 8; j++) b[j] = bitq[j];
        bitq.delete();
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else                      ovf_exp = 1'b1;
      end
    end
  endfunction

  function automatic void commit();
    if (p_rst) begin
      model_clear();
      hold_exp = 8'h00;
    end else if (p_start) begin
      model_clear();
    end else if (p_ce) begin
      model_word(p_d);
    end
  endfunction

  // Inputs change 1 time unit after the edge; the model absorbs the previous cycle's stimulus first.
  task automatic drive(input logic r, input logic s, input logic c, input logic [2:0] dd, input logic rd);
    @(posedge clk);
    #1;
    commit();
    mon_en    = 1'b1;
    rst       = r;
    bus.start = s;
    bus.ce    = c;
    bus.d     = dd;
    bus.rdy   = rd;
    p_rst     = r;
    p_start   = s;
    p_ce      = c;
    p_d       = dd;
  endtask

  task automatic word(input logic [2:0] dd, input logic rd);
    drive(1'b0, 1'b0, 1'b1, dd, rd);
  endtask

  task automatic idle(input logic rd);
    drive(1'b0, 1'b0, 1'b0, 3'd0, rd);
  endtask

  task automatic frame_start(input logic rd);
    drive(1'b0, 1'b1, 1'b1, 3'b111, rd);
    repeat (LAT) word(3'b111, rd);
  endtask

  // Monitor: compares the DUT head against the scoreboard each cycle and retires bytes on dv & rdy.
  always @(negedge clk) begin
    if (mon_en) begin
      check("dv", {31'd0, bus.dv}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) hold_exp = exp_q[0];
      check("dout", {24'd0, bus.dout}, {24'd0, hold_exp});
      check("ovf", {31'd0, bus.ovf}, {31'd0, ovf_exp});
      if (bus.rdy && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    int n;
    logic rdy_bias;
    rst = 1'b1; bus.start = 1'b0; bus.ce = 1'b0; bus.d = 3'd0; bus.rdy = 1'b0;
    p_rst = 1'b1; p_start = 1'b0; p_ce = 1'b0; p_d = 3'd0;

    drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(1'b0);
    check("reset_dout", {24'd0, bus.dout}, 32'h00);
    check("reset_dv", {31'd0, bus.dv}, 32'd0);
    check("reset_ovf", {31'd0, bus.ovf}, 32'd0);

    // Word order: 101,110,011 after discard gives one byte with one bit left over.
    frame_start(1'b1);
    word(3'b101, 1'b1);
    word(3'b110, 1'b1);
    word(3'b011, 1'b1);
    idle(1'b1);
    check("order_dv_up", {31'd0, bus.dv}, 32'd1);
`ifndef BP437_DESCRAMBLE_EN
    check("order_byte", {24'd0, bus.dout}, 32'hF5);
`endif
    idle(1'b1);
    check("order_dv_one_cycle", {31'd0, bus.dv}, 32'd0);

    // Throughput: eight words of ones give three bytes.
    frame_start(1'b1);
    repeat (8) word(3'b111, 1'b1);
    repeat (3) idle(1'b1);
    check("thru_ovf", {31'd0, bus.ovf}, 32'd0);

    // Overflow with rdy held low, then drain.
    frame_start(1'b0);
    repeat (40) word(3'b111, 1'b0);
    idle(1'b0);
    check("ovf_set", {31'd0, bus.ovf}, 32'd1);
    check("ovf_dv", {31'd0, bus.dv}, 32'd1);
    n = 0;
    repeat (6) begin
      idle(1'b1);
      if (bus.dv) n++;
    end
    check("ovf_pops", n, 32'd4);
    check("ovf_drained_dv", {31'd0, bus.dv}, 32'd0);
    check("ovf_sticky", {31'd0, bus.ovf}, 32'd1);

    // Full FIFO with a pop in the cycle a byte completes.
    frame_start(1'b0);
    repeat (11) word(3'b111, 1'b0);
    word(3'b111, 1'b0);
    word(3'b111, 1'b0);
    word(3'b111, 1'b1);
    idle(1'b0);
    check("full_pushpop_ovf", {31'd0, bus.ovf}, 32'd0);
    n = 0;
    repeat (8) begin
      idle(1'b1);
      if (bus.dv) n++;
    end
    check("full_pushpop_occ", n, 32'd4);

    // Mid-frame restart with start: ovf set, two bytes queued, five bits pending.
    frame_start(1'b0);
    repeat (40) word(3'b111, 1'b0);
    repeat (5) idle(1'b1);
    repeat (7) word(3'b010, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 3'b111, 1'b0);
    idle(1'b0);
    check("restart_dv", {31'd0, bus.dv}, 32'd0);
    check("restart_ovf", {31'd0, bus.ovf}, 32'd0);
    repeat (LAT) word(3'b111, 1'b0);
    idle(1'b0);
    check("restart_discard", {31'd0, bus.dv}, 32'd0);
    repeat (3) word(3'b111, 1'b1);
    repeat (2) idle(1'b1);

    // Same with rst.
    repeat (7) word(3'b110, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 3'b111, 1'b0);
    idle(1'b0);
    check("rst_dout", {24'd0, bus.dout}, 32'h00);
    check("rst_dv", {31'd0, bus.dv}, 32'd0);
    repeat (LAT) word(3'b111, 1'b0);
    idle(1'b0);
    check("rst_discard", {31'd0, bus.dv}, 32'd0);

    // Zero words: the byte equals the whitening key when descrambling.
    frame_start(1'b0);
    repeat (3) word(3'b000, 1'b0);
    idle(1'b0);
    check("zero_words_byte", {24'd0, bus.dout}, {24'd0, ZERO_WORDS_BYTE});

    // Random traffic with alternating consumer behaviour and occasional restarts.
    rdy_bias = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 97 == 0) rdy_bias = ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 999) == 0,
            $urandom_range(0, 399) == 0,
            $urandom_range(0, 99) < 75,
            3'($urandom),
            rdy_bias ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 1));
    end
    repeat (10) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
